// File: rtl/raman_acq_pkg.sv
// Shared types and constants for the Raman acquisition sequencer.
package raman_acq_pkg;

  localparam int POINT_W   = 11;
  localparam int MEASURE_W = 17;
  localparam int SAVE_W    = 4;

  localparam logic STOKES     = 1'b1;
  localparam logic ANTISTOKES = 1'b0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHOT,
    S_SETTLE,
    S_SAVE
  } acq_state_t;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int unsigned width_for(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/raman_acq_sequencer_wrap_counter.sv
// Up-counter that returns to zero after TERMINAL; wrap flags the enabled terminal cycle.
module wrap_counter #(
  parameter int unsigned      WIDTH    = 8,
  parameter logic [WIDTH-1:0] TERMINAL = '1
) (
  input  logic             clk,
  input  logic             enable,
  input  logic             clear,
  output logic [WIDTH-1:0] count,
  output logic             wrap
);

  assign wrap = enable && (count == TERMINAL);

  always_ff @(posedge clk) begin
    if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= wrap ? '0 : count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/raman_acq_sequencer.sv
// Raman channel acquisition sequencer: laser shots, Stokes/anti-Stokes switching
// with optical settling, then a handshaked save phase.
//
// state    | meaning
// S_IDLE   | counters and switch held at 0, waiting for start
// S_SHOT   | shots running, cnt_point sweeps 0..POINTS+GUARD
// S_SETTLE | optical switch settling after anti-Stokes -> Stokes change
// S_SAVE   | save_req high, one cnt_save step per save_ack
module raman_acq_sequencer
  import raman_acq_pkg::*;
#(
  parameter int unsigned POINTS     = 1500,
  parameter int unsigned GUARD      = 50,
  parameter int unsigned MEASURES   = 65536,
  parameter int unsigned SETTLE     = 1000,
  parameter int unsigned SAVE_STEPS = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 stop,
  input  logic                 save_ack,
  output logic [POINT_W-1:0]   cnt_point,
  output logic [MEASURE_W-1:0] cnt_measure,
  output logic [SAVE_W-1:0]    cnt_save,
  output logic                 laser_trig,
  output logic                 sample_en,
  output logic                 switch,
  output logic                 save_req,
  output logic                 busy,
  output logic                 done
);

  localparam int unsigned            SETTLE_W     = width_for(SETTLE);
  localparam logic [POINT_W-1:0]     POINT_TERM   = POINT_W'(POINTS + GUARD);
  localparam logic [POINT_W-1:0]     POINT_NUM    = POINT_W'(POINTS);
  localparam logic [MEASURE_W-1:0]   MEASURE_TERM = MEASURE_W'(MEASURES - 1);
  localparam logic [SETTLE_W-1:0]    SETTLE_TERM  = SETTLE_W'(SETTLE - 1);
  localparam logic [SAVE_W-1:0]      SAVE_LAST    = SAVE_W'(SAVE_STEPS - 1);

  acq_state_t state;

  logic                in_shot;
  logic                in_settle;
  logic                abort;
  logic                point_wrap;
  logic                measure_wrap;
  logic                settle_wrap;
  logic [POINT_W-1:0]  point_next;
  logic [SETTLE_W-1:0] settle_cnt_unused;

  assign in_shot   = (state == S_SHOT);
  assign in_settle = (state == S_SETTLE);
  assign abort     = stop && (in_shot || in_settle);

  wrap_counter #(
    .WIDTH    (POINT_W),
    .TERMINAL (POINT_TERM)
  ) u_point_cnt (
    .clk    (clk),
    .enable (in_shot),
    .clear  (rst || abort || !in_shot),
    .count  (cnt_point),
    .wrap   (point_wrap)
  );

  // Shot index only moves on the point wrap, so it is 0 again at the channel end.
  wrap_counter #(
    .WIDTH    (MEASURE_W),
    .TERMINAL (MEASURE_TERM)
  ) u_measure_cnt (
    .clk    (clk),
    .enable (point_wrap),
    .clear  (rst || abort || (state == S_IDLE)),
    .count  (cnt_measure),
    .wrap   (measure_wrap)
  );

  wrap_counter #(
    .WIDTH    (SETTLE_W),
    .TERMINAL (SETTLE_TERM)
  ) u_settle_cnt (
    .clk    (clk),
    .enable (in_settle),
    .clear  (rst || abort || !in_settle),
    .count  (settle_cnt_unused),
    .wrap   (settle_wrap)
  );

  // Point value the counter will hold next cycle; drives the registered strobes.
  assign point_next = point_wrap ? '0 : cnt_point + POINT_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      cnt_save   <= '0;
      laser_trig <= 1'b0;
      sample_en  <= 1'b0;
      switch     <= ANTISTOKES;
      save_req   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      done       <= 1'b0;
      laser_trig <= 1'b0;
      sample_en  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start && !stop) begin
            state      <= S_SHOT;
            busy       <= 1'b1;
            laser_trig <= 1'b1;
            sample_en  <= (POINT_NUM != '0);
          end
        end
        S_SHOT: begin
          if (stop) begin
            state  <= S_IDLE;
            busy   <= 1'b0;
            switch <= ANTISTOKES;
          end else if (measure_wrap) begin
            if (switch == ANTISTOKES) begin
              switch <= STOKES;
              state  <= S_SETTLE;
            end else begin
              state    <= S_SAVE;
              save_req <= 1'b1;
            end
          end else begin
            laser_trig <= point_wrap;
            sample_en  <= (point_next < POINT_NUM);
          end
        end
        S_SETTLE: begin
          if (stop) begin
            state  <= S_IDLE;
            busy   <= 1'b0;
            switch <= ANTISTOKES;
          end else if (settle_wrap) begin
            state      <= S_SHOT;
            laser_trig <= 1'b1;
            sample_en  <= (POINT_NUM != '0);
          end
        end
        S_SAVE: begin
          if (save_ack) begin
            if (cnt_save == SAVE_LAST) begin
              cnt_save <= '0;
              save_req <= 1'b0;
              switch   <= ANTISTOKES;
              done     <= 1'b1;
              busy     <= 1'b0;
              state    <= S_IDLE;
            end else begin
              cnt_save <= cnt_save + SAVE_W'(1);
            end
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
